stream_mux_n: RTL and testbench

//  N-channel, DATA_W-bit streaming multiplexer with valid/ready handshakes and packet locking.

---
 rtl/stream_mux_pkg.sv | 14 +
 rtl/stream_mux_n_rr_pick.sv | 41 ++++
 rtl/stream_mux_n.sv | 147 ++++++++++++++
 tb/tb_stream_mux_n.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream_mux_n block.
//   MODE_SEL / MODE_RR : channel-selection policy for the top-level MODE parameter
//   state_t            : packet-lock FSM encoding
package stream_mux_pkg;

  localparam int MODE_SEL = 0;  // channel chosen by the external sel port
  localparam int MODE_RR  = 1;  // channel chosen by the rotating-priority picker

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/stream_mux_n_rr_pick.sv
// Combinational rotate-priority picker.
// Scans req starting one position after ptr, wrapping modulo N_CH, and returns
// the first requesting index.
//   req   : per-channel request vector
//   ptr   : index that was served last (lowest priority this round)
//   idx   : chosen channel (0 when found=0)
//   found : at least one request is present
module rr_pick #(
  parameter int N_CH  = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [SEL_W:0]   sum;
  logic [SEL_W-1:0] pos;

  // Walk the offsets from farthest to nearest so the nearest requester after
  // ptr is the last assignment and therefore wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int k = N_CH; k >= 1; k--) begin
      sum = {1'b0, ptr} + (SEL_W+1)'(k);
      if (sum >= (SEL_W+1)'(N_CH)) begin
        sum = sum - (SEL_W+1)'(N_CH);
      end
      pos = sum[SEL_W-1:0];
      if (req[pos]) begin
        idx   = pos;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_n.sv
// N-channel valid/ready stream multiplexer with packet locking.
// Once the first beat of a multi-beat packet is accepted, the source channel
// keeps the grant until its last beat passes. Output stage is a single register
// slice: one cycle latency, one beat per cycle while the sink is ready.
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   sel              : channel select (MODE_SEL only)
//   in_data/valid/last, in_ready : per-channel input streams
//   out_data/valid/last, out_chan, out_ready : registered output stream
//
//   state     | meaning
//   ST_IDLE   | between packets; next candidate from sel or the RR picker
//   ST_LOCKED | mid-packet; only channel 'grant' may transfer
module stream_mux_n
  import stream_mux_pkg::*;
#(
  parameter int N_CH   = 8,
  parameter int DATA_W = 8,
  parameter int MODE   = MODE_SEL,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic [N_CH-1:0]        in_valid,
  input  logic [N_CH-1:0]        in_last,
  output logic [N_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  output logic                   out_last,
  output logic [SEL_W-1:0]       out_chan,
  input  logic                   out_ready
);

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   grant, grant_nxt;
  logic [SEL_W-1:0]   ptr, ptr_nxt;
  logic [SEL_W-1:0]   cand;
  logic [SEL_W-1:0]   rr_idx;
  logic               rr_found;
  logic               cand_ok;
  logic               c_valid;
  logic               c_last;
  logic [DATA_W-1:0]  c_data;
  logic               load;
  logic               xfer;

  generate
    if (MODE == MODE_RR) begin : g_rr
      rr_pick #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
      ) u_rr_pick (
        .req   (in_valid),
        .ptr   (ptr),
        .idx   (rr_idx),
        .found (rr_found)
      );
    end else begin : g_no_rr
      assign rr_idx   = '0;
      assign rr_found = 1'b0;
    end
  endgenerate

  // The output register can take a new beat when empty or draining this edge.
  assign load = !out_valid || out_ready;

  always_comb begin
    cand    = grant;
    c_valid = 1'b0;
    c_last  = 1'b0;
    c_data  = '0;
    in_ready = '0;

    if (state == ST_IDLE) begin
      cand = (MODE == MODE_RR) ? rr_idx : sel;
    end

    // Decoded mux: a sel value beyond N_CH-1 matches no channel and so
    // naturally yields no candidate.
    for (int i = 0; i < N_CH; i++) begin
      if (cand == SEL_W'(i)) begin
        c_valid = in_valid[i];
        c_last  = in_last[i];
        c_data  = in_data[i*DATA_W +: DATA_W];
      end
    end

    cand_ok = c_valid;
    if (state == ST_IDLE && MODE == MODE_RR) begin
      cand_ok = rr_found;
    end

    for (int i = 0; i < N_CH; i++) begin
      if (cand == SEL_W'(i)) begin
        in_ready[i] = load && cand_ok;
      end
    end
  end

  assign xfer = load && cand_ok;

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    ptr_nxt   = ptr;
    if (xfer) begin
      ptr_nxt = cand;
      if (c_last) begin
        state_nxt = ST_IDLE;
      end else begin
        state_nxt = ST_LOCKED;
        grant_nxt = cand;
      end
    end
  end

  // ptr starts at the top channel so the first scan begins at channel 0.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= ST_IDLE;
      grant <= '0;
      ptr   <= SEL_W'(N_CH-1);
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_chan  <= '0;
    end else if (load) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= c_data;
        out_last <= c_last;
        out_chan <= cand;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_n.sv
// Scoreboard bench for stream_mux_n: one MODE_SEL and one MODE_RR instance.
// Sources are per-channel queues; expected output beats are queued by the
// stimulus and popped by a monitor whenever an output beat completes.
module tb_stream_mux_n;
  import stream_mux_pkg::*;

  typedef struct packed { logic [7:0] d; logic l; } src_t;
  typedef struct packed { logic [7:0] d; logic l; logic [2:0] c; } exp_t;

  logic clk;
  logic rst_s, rst_r;
  logic [2:0]  sel_s, sel_r;
  logic [63:0] din_s, din_r;
  logic [7:0]  vld_s, vld_r, lst_s, lst_r, rdy_s, rdy_r;
  logic [7:0]  od_s, od_r;
  logic        ov_s, ov_r, ol_s, ol_r, ordy_s, ordy_r;
  logic [2:0]  oc_s, oc_r;

  src_t srcq_s[8][$];
  src_t srcq_r[8][$];
  exp_t exp_s[$];
  exp_t exp_r[$];

  int n_tests = 0;
  int n_fail  = 0;

  stream_mux_n #(.N_CH(8), .DATA_W(8), .MODE(MODE_SEL)) dut_sel (
    .sys_clk(clk), .sys_rst(rst_s), .sel(sel_s),
    .in_data(din_s), .in_valid(vld_s), .in_last(lst_s), .in_ready(rdy_s),
    .out_data(od_s), .out_valid(ov_s), .out_last(ol_s), .out_chan(oc_s),
    .out_ready(ordy_s)
  );

  stream_mux_n #(.N_CH(8), .DATA_W(8), .MODE(MODE_RR)) dut_rr (
    .sys_clk(clk), .sys_rst(rst_r), .sel(sel_r),
    .in_data(din_r), .in_valid(vld_r), .in_last(lst_r), .in_ready(rdy_r),
    .out_data(od_r), .out_valid(ov_r), .out_last(ol_r), .out_chan(oc_r),
    .out_ready(ordy_r)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Source driver: handshake decided mid-cycle, queues advanced after the edge.
  initial begin : driver
    logic [7:0] fire_s, fire_r;
    vld_s = '0; vld_r = '0; lst_s = '0; lst_r = '0; din_s = '0; din_r = '0;
    forever begin
      @(negedge clk);
      fire_s = rst_s ? 8'h00 : (vld_s & rdy_s);
      fire_r = rst_r ? 8'h00 : (vld_r & rdy_r);
      @(posedge clk);
      #2;
      for (int i = 0; i < 8; i++) begin
        if (fire_s[i] && srcq_s[i].size() > 0) void'(srcq_s[i].pop_front());
        if (fire_r[i] && srcq_r[i].size() > 0) void'(srcq_r[i].pop_front());
        vld_s[i] = (srcq_s[i].size() > 0);
        vld_r[i] = (srcq_r[i].size() > 0);
        lst_s[i] = vld_s[i] ? srcq_s[i][0].l : 1'b0;
        lst_r[i] = vld_r[i] ? srcq_r[i][0].l : 1'b0;
        din_s[i*8 +: 8] = vld_s[i] ? srcq_s[i][0].d : 8'h00;
        din_r[i*8 +: 8] = vld_r[i] ? srcq_r[i][0].d : 8'h00;
      end
    end
  end

  // Monitor: every completed output beat must match the head of its queue.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_s && ov_s && ordy_s) begin
        if (exp_s.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sel_extra_beat: got data %0h chan %0d expected none", od_s, oc_s);
        end else begin
          e = exp_s.pop_front();
          check("sel_beat", {od_s, ol_s, oc_s}, {e.d, e.l, e.c});
        end
      end
      if (!rst_r && ov_r && ordy_r) begin
        if (exp_r.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rr_extra_beat: got data %0h chan %0d expected none", od_r, oc_r);
        end else begin
          e = exp_r.pop_front();
          check("rr_beat", {od_r, ol_r, oc_r}, {e.d, e.l, e.c});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int k = 0;
    while ((exp_s.size() != 0 || exp_r.size() != 0) && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    check(name, exp_s.size() + exp_r.size(), 0);
  endtask

  task automatic push_s(input int ch, input logic [7:0] d, input logic l);
    srcq_s[ch].push_back('{d: d, l: l});
    exp_s.push_back('{d: d, l: l, c: 3'(ch)});
  endtask

  task automatic push_r(input int ch, input logic [7:0] d, input logic l);
    srcq_r[ch].push_back('{d: d, l: l});
    exp_r.push_back('{d: d, l: l, c: 3'(ch)});
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int k;
    int run;
    rst_s = 1'b1; rst_r = 1'b1;
    sel_s = '0; sel_r = '0;
    ordy_s = 1'b1; ordy_r = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_s = 1'b0; rst_r = 1'b0;
    @(negedge clk);
    check("reset_valid_s", ov_s, 0);
    check("reset_data_s", od_s, 0);
    check("reset_last_s", ol_s, 0);
    check("reset_chan_s", oc_s, 0);
    check("reset_valid_r", ov_r, 0);

    // 1: single-beat packet on ch3
    tick();
    sel_s = 3'd3;
    push_s(3, 8'hA5, 1'b1);
    @(negedge clk);
    check("t1_ready", rdy_s, 8'h08);
    @(negedge clk);
    check("t1_valid", ov_s, 1);
    check("t1_data", od_s, 8'hA5);
    check("t1_chan", oc_s, 3);
    check("t1_last", ol_s, 1);
    wait_drain("t1_drain", 20);

    // sel points at an idle channel: nobody is ready
    tick();
    sel_s = 3'd2;
    srcq_s[6].push_back('{d: 8'h66, l: 1'b1});
    @(negedge clk);
    check("nocand_ready", rdy_s, 8'h00);
    check("nocand_valid", ov_s, 0);
    tick();
    sel_s = 3'd6;
    exp_s.push_back('{d: 8'h66, l: 1'b1, c: 3'd6});
    wait_drain("nocand_drain", 20);

    // 2: packet lock survives a sel change
    tick();
    sel_s = 3'd2;
    push_s(2, 8'h11, 1'b0);
    push_s(2, 8'h22, 1'b0);
    push_s(2, 8'h33, 1'b1);
    push_s(5, 8'h55, 1'b1);
    tick();
    sel_s = 3'd5;
    @(negedge clk);
    check("t2_lock_ready", rdy_s, 8'h04);
    wait_drain("t2_drain", 30);

    // 4: backpressure mid-packet
    tick();
    sel_s = 3'd1;
    for (int i = 1; i <= 6; i++) push_s(1, 8'h40 + 8'(i), (i == 6));
    tick();
    tick();
    ordy_s = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t4_hold_data", od_s, 8'h42);
      check("t4_hold_valid", ov_s, 1);
      check("t4_ready_low", rdy_s, 8'h00);
    end
    tick();
    ordy_s = 1'b1;
    wait_drain("t4_drain", 30);

    // 5: full-rate 16-beat packet
    tick();
    sel_s = 3'd4;
    for (int i = 0; i < 16; i++) push_s(4, 8'(i), (i == 15));
    @(negedge clk);
    k = 0;
    while (!ov_s && k < 8) begin
      @(negedge clk);
      k++;
    end
    run = 0;
    while (ov_s && run < 20) begin
      run++;
      @(negedge clk);
    end
    check("t5_run", run, 16);
    wait_drain("t5_drain", 10);

    // 3: round-robin over ch0, ch1, ch7
    tick();
    for (int b = 0; b < 2; b++) begin
      push_r(0, 8'h00 + 8'(b), 1'b1);
      push_r(1, 8'h10 + 8'(b), 1'b1);
      push_r(7, 8'h70 + 8'(b), 1'b1);
    end
    // queue order above already matches the expected 0,1,7,0,1,7 rotation
    @(negedge clk);
    check("t3_first_grant", rdy_r, 8'h01);
    wait_drain("t3_drain", 30);

    // 6: reset during a locked ch6 packet
    tick();
    ordy_r = 1'b0;
    for (int i = 0; i < 4; i++) srcq_r[6].push_back('{d: 8'h60 + 8'(i), l: (i == 3)});
    tick();
    tick();
    @(negedge clk);
    check("t6_stall_valid", ov_r, 1);
    check("t6_stall_data", od_r, 8'h60);
    check("t6_stall_ready", rdy_r, 8'h00);
    tick();
    rst_r = 1'b1;
    srcq_r[6].delete();
    tick();
    rst_r = 1'b0;
    ordy_r = 1'b1;
    @(negedge clk);
    check("t6_post_valid", ov_r, 0);
    check("t6_post_ready", rdy_r, 8'h00);
    tick();
    push_r(1, 8'h81, 1'b1);
    push_r(6, 8'h86, 1'b1);
    @(negedge clk);
    check("t6_ch1_first", rdy_r, 8'h02);
    wait_drain("t6_drain", 20);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
